eth_hdr_extract: RTL and testbench

- Ethernet L2 header extraction stage; it consumes the same beat stream whose accepted beats the byte counter counts.
- Accepts frame beats on a valid/ready stream and captures destination MAC, source MAC, an optional single 802.1Q tag and the EtherType.
- Presents the captured fields as one record on a valid/ready header port, then passes the frame remainder through until end of frame.
- Drives frame_start/beat_accept for the byte counter placed alongside it.

---
 rtl/eth_pkg.sv | 56 +++++
 rtl/hdr_byte_capture.sv | 48 ++++
 rtl/eth_hdr_extract.sv | 151 +++++++++++++++
 tb/tb_eth_hdr_extract.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet L2 header extraction stage.
package eth_pkg;

    localparam int          ETH_HDR_BYTES      = 14;
    localparam int          ETH_VLAN_HDR_BYTES = 18;
    localparam logic [15:0] ETH_TPID_VLAN      = 16'h8100;
    localparam int          MAC_W              = 48;

    // The shadow register is sized for the longest header we ever parse.
    localparam int          SHADOW_BYTES       = ETH_VLAN_HDR_BYTES;

    typedef struct packed {
        logic [MAC_W-1:0] dst;
        logic [MAC_W-1:0] src;
        logic             vlan;
        logic [15:0]      tci;
        logic [15:0]      ethertype;
    } eth_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HOLD,
        HOLD_LAST,
        PAYLOAD
    } hdr_state_t;

    // Byte index arithmetic sticks at all-ones instead of wrapping on very long frames.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Turns the wire-order header bytes into the output record.
    // Byte 0 on the wire is the most significant byte of the destination MAC.
    function automatic eth_hdr_t pack_hdr(input logic [SHADOW_BYTES-1:0][7:0] b,
                                          input logic                         vlan);
        eth_hdr_t h;
        h = '0;
        for (int i = 0; i < 6; i++) begin
            h.dst[8*(5-i) +: 8] = b[i];
            h.src[8*(5-i) +: 8] = b[6+i];
        end
        h.vlan = vlan;
        if (vlan) begin
            h.tci       = {b[14], b[15]};
            h.ethertype = {b[16], b[17]};
        end else begin
            h.tci       = 16'h0000;
            h.ethertype = {b[12], b[13]};
        end
        return h;
    endfunction

endpackage

// File: rtl/hdr_byte_capture.sv
// Header shadow register: each lane of an incoming beat lands at byte offset
// (index + lane) while that offset still lies inside the header window.
// merged_o shows the register contents with the current beat already applied,
// so the parser can decide on the tag and load the record in the same cycle.
module hdr_byte_capture
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en_i,
    input  logic [15:0]                 index_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [SHADOW_BYTES-1:0][7:0] merged_o
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [SHADOW_BYTES-1:0][7:0] shadow_q;
    logic [SHADOW_BYTES-1:0][7:0] shadow_d;

    // Per-byte write enables decoded from (index, lane); lanes past the window are dropped.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            for (int k = 0; k < SHADOW_BYTES; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    if ((int'(index_i) + l) == k) begin
                        shadow_d[k] = data_i[8*l +: 8];
                    end
                end
            end
        end
    end

    // Shadow bytes persist between beats so a header can be assembled across many cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign merged_o = shadow_d;

endmodule

// File: rtl/eth_hdr_extract.sv
// Ethernet L2 header extraction: captures DA, SA, an optional 802.1Q tag and
// the EtherType from a valid/ready beat stream, offers them as one record on
// the header port, then lets the rest of the frame flow through untouched.
module eth_hdr_extract
    import eth_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter logic [15:0] TPID_VLAN  = ETH_TPID_VLAN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  beat_accept,
    output logic                  frame_start,
    output logic [MAC_W-1:0]      hdr_dst_mac,
    output logic [MAC_W-1:0]      hdr_src_mac,
    output logic                  hdr_vlan,
    output logic [15:0]           hdr_vlan_tci,
    output logic [15:0]           hdr_ethertype,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic                  hdr_err
);

    localparam int          LANES   = DATA_WIDTH / 8;
    localparam logic [15:0] LANES16 = 16'(LANES);
    localparam logic [16:0] LANES17 = 17'(LANES);

    hdr_state_t                   state_q;
    hdr_state_t                   state_d;
    logic [15:0]                  byteIdx_q;
    logic [15:0]                  byteIdx_d;
    eth_hdr_t                     hdr_q;
    eth_hdr_t                     hdr_d;
    logic                         hdrErr_q;
    logic                         hdrErr_d;

    logic                         sReady;
    logic                         accept;
    logic                         capture;
    logic [15:0]                  captIdx;
    logic [16:0]                  beatEnd;
    logic                         isVlan;
    logic                         hdrDone;
    logic [SHADOW_BYTES-1:0][7:0] mergedBytes;

    hdr_byte_capture #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (capture),
        .index_i  (captIdx),
        .data_i   (s_data),
        .merged_o (mergedBytes)
    );

    // Beat acceptance and header-completion decode for the beat on the bus this cycle.
    always_comb begin
        sReady  = (state_q == IDLE) || (state_q == HDR) || (state_q == PAYLOAD);
        accept  = s_valid && sReady;
        capture = accept && ((state_q == IDLE) || (state_q == HDR));
        captIdx = (state_q == IDLE) ? 16'h0000 : byteIdx_q;
        beatEnd = {1'b0, captIdx} + LANES17;
        isVlan  = ({mergedBytes[12], mergedBytes[13]} == TPID_VLAN);
        // The tag bytes are only trustworthy once this frame has reached byte 13;
        // before that the shadow still holds bytes from an earlier frame.
        hdrDone = (beatEnd >= 17'(ETH_HDR_BYTES)) &&
                  (!isVlan || (beatEnd >= 17'(ETH_VLAN_HDR_BYTES)));
    end

    // Frame-level FSM: parse header, hold the record until taken, pass payload.
    always_comb begin
        state_d   = state_q;
        byteIdx_d = byteIdx_q;
        hdr_d     = hdr_q;
        hdrErr_d  = 1'b0;
        unique case (state_q)
            IDLE, HDR: begin
                if (accept) begin
                    byteIdx_d = sat_add16(captIdx, LANES16);
                    if (hdrDone) begin
                        hdr_d   = pack_hdr(mergedBytes, isVlan);
                        state_d = s_last ? HOLD_LAST : HOLD;
                    end else if (s_last) begin
                        hdrErr_d  = 1'b1;
                        byteIdx_d = 16'h0000;
                        state_d   = IDLE;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HOLD: begin
                if (hdr_ready) begin
                    state_d = PAYLOAD;
                end
            end
            HOLD_LAST: begin
                if (hdr_ready) begin
                    byteIdx_d = 16'h0000;
                    state_d   = IDLE;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (s_last) begin
                        byteIdx_d = 16'h0000;
                        state_d   = IDLE;
                    end else begin
                        byteIdx_d = sat_add16(byteIdx_q, LANES16);
                    end
                end
            end
            default: begin
                byteIdx_d = 16'h0000;
                state_d   = IDLE;
            end
        endcase
    end

    // State, byte index, header record and runt pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            byteIdx_q <= 16'h0000;
            hdr_q     <= '0;
            hdrErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteIdx_q <= byteIdx_d;
            hdr_q     <= hdr_d;
            hdrErr_q  <= hdrErr_d;
        end
    end

    assign s_ready       = sReady;
    assign beat_accept   = accept;
    assign frame_start   = accept && (state_q == IDLE);
    assign hdr_valid     = (state_q == HOLD) || (state_q == HOLD_LAST);
    assign hdr_err       = hdrErr_q;
    assign hdr_dst_mac   = hdr_q.dst;
    assign hdr_src_mac   = hdr_q.src;
    assign hdr_vlan      = hdr_q.vlan;
    assign hdr_vlan_tci  = hdr_q.tci;
    assign hdr_ethertype = hdr_q.ethertype;

endmodule

// File: tb/tb_eth_hdr_extract.sv
// Scoreboard bench for eth_hdr_extract: one 8-bit and one 64-bit instance.
module tb_eth_hdr_extract;

    typedef struct {
        bit          isErr;
        logic [47:0] dst;
        logic [47:0] src;
        logic        vlan;
        logic [15:0] tci;
        logic [15:0] etype;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, sValid8, sLast8, sReady8, beatAccept8, frameStart8;
    logic        hdrVlan8, hdrValid8, hdrReady8, hdrErr8;
    logic [7:0]  sData8;
    logic [47:0] hdrDst8, hdrSrc8;
    logic [15:0] hdrTci8, hdrType8;

    logic        rst64, sValid64, sLast64, sReady64, beatAccept64, frameStart64;
    logic        hdrVlan64, hdrValid64, hdrReady64, hdrErr64;
    logic [63:0] sData64;
    logic [47:0] hdrDst64, hdrSrc64;
    logic [15:0] hdrTci64, hdrType64;

    expT         q8[$];
    expT         q64[$];
    int          errors = 0;
    int          checks = 0;
    bit          monOn = 1'b0;
    int          fs8 = 0, fs64 = 0, ba8 = 0, ba64 = 0;
    logic        prevValid8 = 1'b0, prevHs8 = 1'b0, prevValid64 = 1'b0, prevHs64 = 1'b0;
    logic [7:0]  frm [0:127];

    eth_hdr_extract #(.DATA_WIDTH(8), .TPID_VLAN(16'h8100)) dut8 (
        .clk(clk), .rst(rst8), .s_data(sData8), .s_valid(sValid8), .s_last(sLast8),
        .s_ready(sReady8), .beat_accept(beatAccept8), .frame_start(frameStart8),
        .hdr_dst_mac(hdrDst8), .hdr_src_mac(hdrSrc8), .hdr_vlan(hdrVlan8),
        .hdr_vlan_tci(hdrTci8), .hdr_ethertype(hdrType8), .hdr_valid(hdrValid8),
        .hdr_ready(hdrReady8), .hdr_err(hdrErr8)
    );

    eth_hdr_extract #(.DATA_WIDTH(64), .TPID_VLAN(16'h8100)) dut64 (
        .clk(clk), .rst(rst64), .s_data(sData64), .s_valid(sValid64), .s_last(sLast64),
        .s_ready(sReady64), .beat_accept(beatAccept64), .frame_start(frameStart64),
        .hdr_dst_mac(hdrDst64), .hdr_src_mac(hdrSrc64), .hdr_vlan(hdrVlan64),
        .hdr_vlan_tci(hdrTci64), .hdr_ethertype(hdrType64), .hdr_valid(hdrValid64),
        .hdr_ready(hdrReady64), .hdr_err(hdrErr64)
    );

    function automatic expT mkExp(input bit isErr, input logic [47:0] dst, input logic [47:0] src,
                                  input logic vlan, input logic [15:0] tci, input logic [15:0] etype);
        expT e;
        e.isErr = isErr; e.dst = dst; e.src = src; e.vlan = vlan; e.tci = tci; e.etype = etype;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Fills frm[] with a frame whose header bytes are laid out in wire order.
    task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic vlan,
                              input logic [15:0] tci, input logic [15:0] etype, input int len);
        for (int i = 0; i < len; i++) frm[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 6; i++) begin
            frm[i]   = dst[8*(5-i) +: 8];
            frm[6+i] = src[8*(5-i) +: 8];
        end
        if (vlan) begin
            frm[12] = 8'h81; frm[13] = 8'h00;
            frm[14] = tci[15:8]; frm[15] = tci[7:0];
            frm[16] = etype[15:8]; frm[17] = etype[7:0];
        end else begin
            frm[12] = etype[15:8]; frm[13] = etype[7:0];
        end
    endtask

    // Drives one beat and holds it until accepted; validMode 1/2 checks hdr_valid 0/1 on the first sample.
    task automatic applyStimulus(input bit wide, input logic [63:0] data, input logic last,
                                 input bit first, input int validMode, output int waitCycles);
        bit accepted;
        accepted   = 1'b0;
        waitCycles = 0;
        if (wide) begin sValid64 = 1'b1; sData64 = data; sLast64 = last; end
        else      begin sValid8  = 1'b1; sData8  = data[7:0]; sLast8 = last; end
        for (int c = 0; c < 64 && !accepted; c++) begin
            @(negedge clk);
            if (c == 0 && validMode != 0)
                checkOutput("hdr_valid latency", wide ? hdrValid64 : hdrValid8, 64'(validMode == 2));
            if (wide ? sReady64 : sReady8) begin
                accepted = 1'b1;
                checkOutput("frame_start", wide ? frameStart64 : frameStart8, 64'(first));
            end else begin
                waitCycles++;
            end
        end
        if (!accepted) checkOutput("beat accept timeout", 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        if (wide) begin sValid64 = 1'b0; sLast64 = 1'b0; end
        else      begin sValid8  = 1'b0; sLast8  = 1'b0; end
    endtask

    // Sends frm[0..len-1]; hdrLen is 0 for runts, else the header length in bytes.
    task automatic sendFrame(input bit wide, input int len, input int hdrLen, output int stalls);
        int lanes, nBeats, doneBeat, w, mode;
        logic [63:0] data;
        lanes    = wide ? 8 : 1;
        nBeats   = (len + lanes - 1) / lanes;
        doneBeat = (hdrLen > 0) ? (hdrLen - 1) / lanes : -2;
        stalls   = 0;
        for (int b = 0; b < nBeats; b++) begin
            data = '0;
            for (int l = 0; l < lanes; l++)
                if (b * lanes + l < len) data[8*l +: 8] = frm[b * lanes + l];
            mode = (b == doneBeat) ? 1 : ((b == doneBeat + 1) ? 2 : 0);
            applyStimulus(wide, data, b == nBeats - 1, b == 0, mode, w);
            stalls += w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        expT e;
        if (monOn) begin
            if (frameStart8) fs8++;
            if (beatAccept8) ba8++;
            if (hdrErr8) begin
                checks++;
                if (q8.size() == 0 || !q8[0].isErr) begin
                    errors++;
                    $display("[TB] FAIL dw8 hdr_err: got pulse, expected no runt pending");
                end
                if (q8.size() != 0) void'(q8.pop_front());
            end
            if (hdrValid8 && hdrReady8) begin
                checks++;
                if (q8.size() == 0 || q8[0].isErr) begin
                    errors++;
                    $display("[TB] FAIL dw8 header: got record, expected no header pending");
                    if (q8.size() != 0) void'(q8.pop_front());
                end else begin
                    e = q8.pop_front();
                    checkOutput("dw8 dst", hdrDst8, e.dst);
                    checkOutput("dw8 src", hdrSrc8, e.src);
                    checkOutput("dw8 vlan", hdrVlan8, e.vlan);
                    checkOutput("dw8 tci", hdrTci8, e.tci);
                    checkOutput("dw8 ethertype", hdrType8, e.etype);
                end
            end
            if (prevValid8 && !hdrValid8) checkOutput("dw8 hdr_valid drop", prevHs8, 64'd1);
            prevValid8 = hdrValid8;
            prevHs8    = hdrValid8 && hdrReady8;
        end
    end

    // Scoreboard monitor for the 64-bit instance.
    always @(negedge clk) begin : mon64
        expT e;
        if (monOn) begin
            if (frameStart64) fs64++;
            if (beatAccept64) ba64++;
            if (hdrErr64) begin
                checks++;
                if (q64.size() == 0 || !q64[0].isErr) begin
                    errors++;
                    $display("[TB] FAIL dw64 hdr_err: got pulse, expected no runt pending");
                end
                if (q64.size() != 0) void'(q64.pop_front());
            end
            if (hdrValid64 && hdrReady64) begin
                checks++;
                if (q64.size() == 0 || q64[0].isErr) begin
                    errors++;
                    $display("[TB] FAIL dw64 header: got record, expected no header pending");
                    if (q64.size() != 0) void'(q64.pop_front());
                end else begin
                    e = q64.pop_front();
                    checkOutput("dw64 dst", hdrDst64, e.dst);
                    checkOutput("dw64 src", hdrSrc64, e.src);
                    checkOutput("dw64 vlan", hdrVlan64, e.vlan);
                    checkOutput("dw64 tci", hdrTci64, e.tci);
                    checkOutput("dw64 ethertype", hdrType64, e.etype);
                end
            end
            if (prevValid64 && !hdrValid64) checkOutput("dw64 hdr_valid drop", prevHs64, 64'd1);
            prevValid64 = hdrValid64;
            prevHs64    = hdrValid64 && hdrReady64;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls, w, baStart, expFrames8, expBeats8;
        expFrames8 = 0; expBeats8 = 0;
        rst8 = 1'b1; sValid8 = 1'b0; sData8 = '0; sLast8 = 1'b0; hdrReady8 = 1'b1;
        rst64 = 1'b1; sValid64 = 1'b0; sData64 = '0; sLast64 = 1'b0; hdrReady64 = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst8 = 1'b0; rst64 = 1'b0;
        @(negedge clk);
        checkOutput("reset s_ready", sReady8, 64'd1);
        checkOutput("reset hdr_valid", hdrValid8, 64'd0);
        checkOutput("reset hdr_err", hdrErr8, 64'd0);
        checkOutput("reset frame_start", frameStart8, 64'd0);
        checkOutput("reset dst", hdrDst8, 64'd0);
        checkOutput("reset ethertype", hdrType8, 64'd0);
        checkOutput("reset dw64 s_ready", sReady64, 64'd1);
        checkOutput("reset dw64 hdr_valid", hdrValid64, 64'd0);
        monOn = 1'b1;
        idle(1);

        // Untagged 64-byte frame.
        buildFrame(48'h010203040506, 48'h0A0B0C0D0E0F, 1'b0, 16'h0, 16'h0800, 64);
        q8.push_back(mkExp(1'b0, 48'h010203040506, 48'h0A0B0C0D0E0F, 1'b0, 16'h0000, 16'h0800));
        sendFrame(1'b0, 64, 14, stalls); expFrames8++; expBeats8 += 64;
        checkOutput("untagged s_ready low cycles", stalls, 64'd1);
        idle(3);

        // Tagged frame, header completes after byte 17.
        buildFrame(48'hFFFFFFFFFFFF, 48'h001B213C4D5E, 1'b1, 16'h2064, 16'h86DD, 70);
        q8.push_back(mkExp(1'b0, 48'hFFFFFFFFFFFF, 48'h001B213C4D5E, 1'b1, 16'h2064, 16'h86DD));
        sendFrame(1'b0, 70, 18, stalls); expFrames8++; expBeats8 += 70;
        checkOutput("tagged s_ready low cycles", stalls, 64'd1);
        idle(3);

        // Back-pressure: header held 5 cycles before hdr_ready.
        buildFrame(48'h020000000001, 48'h020000000002, 1'b0, 16'h0, 16'h0806, 60);
        q8.push_back(mkExp(1'b0, 48'h020000000001, 48'h020000000002, 1'b0, 16'h0000, 16'h0806));
        hdrReady8 = 1'b0;
        fork
            sendFrame(1'b0, 60, 14, stalls);
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!hdrValid8 && n < 300);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    checkOutput("bp hdr_valid held", hdrValid8, 64'd1);
                    checkOutput("bp s_ready low", sReady8, 64'd0);
                    checkOutput("bp beat_accept", beatAccept8, 64'd0);
                    checkOutput("bp dst stable", hdrDst8, 64'h020000000001);
                    checkOutput("bp ethertype stable", hdrType8, 64'h0806);
                end
                @(posedge clk);
                #1;
                hdrReady8 = 1'b1;
            end
        join
        expFrames8++; expBeats8 += 60;
        checkOutput("bp s_ready low cycles", stalls, 64'd6);
        idle(3);

        // Untagged runt: 10 bytes.
        buildFrame(48'h112233445566, 48'h778899AABBCC, 1'b0, 16'h0, 16'h0800, 10);
        q8.push_back(mkExp(1'b1, 48'h0, 48'h0, 1'b0, 16'h0, 16'h0));
        sendFrame(1'b0, 10, 0, stalls); expFrames8++; expBeats8 += 10;
        checkOutput("runt stalls", stalls, 64'd0);
        idle(3);

        // Frame after the runt parses normally.
        buildFrame(48'h0180C200000E, 48'h00E04C123456, 1'b0, 16'h0, 16'h88CC, 20);
        q8.push_back(mkExp(1'b0, 48'h0180C200000E, 48'h00E04C123456, 1'b0, 16'h0000, 16'h88CC));
        sendFrame(1'b0, 20, 14, stalls); expFrames8++; expBeats8 += 20;
        checkOutput("post-runt stalls", stalls, 64'd1);
        idle(3);

        // Tagged frame ending at byte 15 is a runt even though 14 bytes arrived.
        buildFrame(48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 1'b1, 16'h0005, 16'h0800, 16);
        q8.push_back(mkExp(1'b1, 48'h0, 48'h0, 1'b0, 16'h0, 16'h0));
        sendFrame(1'b0, 16, 0, stalls); expFrames8++; expBeats8 += 16;
        idle(3);

        // Exactly 14 bytes: header completes on the last beat.
        buildFrame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1'b0, 16'h0, 16'h0842, 14);
        q8.push_back(mkExp(1'b0, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1'b0, 16'h0000, 16'h0842));
        sendFrame(1'b0, 14, 14, stalls); expFrames8++; expBeats8 += 14;
        checkOutput("hold_last stalls", stalls, 64'd0);
        idle(3);

        // Reset in the middle of the header after byte 7.
        buildFrame(48'hDEADBEEF0001, 48'hDEADBEEF0002, 1'b0, 16'h0, 16'h0800, 30);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, {56'b0, frm[i]}, 1'b0, i == 0, 0, w);
        expFrames8++; expBeats8 += 8;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        checkOutput("mid reset dst", hdrDst8, 64'd0);
        checkOutput("mid reset src", hdrSrc8, 64'd0);
        checkOutput("mid reset vlan", hdrVlan8, 64'd0);
        checkOutput("mid reset tci", hdrTci8, 64'd0);
        checkOutput("mid reset ethertype", hdrType8, 64'd0);
        checkOutput("mid reset hdr_valid", hdrValid8, 64'd0);
        checkOutput("mid reset s_ready", sReady8, 64'd1);
        idle(1);
        buildFrame(48'h00005E0001FF, 48'h3C5AB4000001, 1'b1, 16'hE00A, 16'h0800, 40);
        q8.push_back(mkExp(1'b0, 48'h00005E0001FF, 48'h3C5AB4000001, 1'b1, 16'hE00A, 16'h0800));
        sendFrame(1'b0, 40, 18, stalls); expFrames8++; expBeats8 += 40;
        checkOutput("post-reset stalls", stalls, 64'd1);
        idle(3);

        // Wide bus, untagged 60-byte frame: 8 beats, header done on beat 1.
        buildFrame(48'h010203040506, 48'h0A0B0C0D0E0F, 1'b0, 16'h0, 16'h0800, 60);
        q64.push_back(mkExp(1'b0, 48'h010203040506, 48'h0A0B0C0D0E0F, 1'b0, 16'h0000, 16'h0800));
        baStart = ba64;
        sendFrame(1'b1, 60, 14, stalls);
        checkOutput("dw64 beat count", ba64 - baStart, 64'd8);
        checkOutput("dw64 stalls", stalls, 64'd1);
        idle(3);

        // Wide bus, tagged 64-byte frame: header done on beat 2.
        buildFrame(48'h001122334455, 48'h66778899AABB, 1'b1, 16'h3FFF, 16'h88F7, 64);
        q64.push_back(mkExp(1'b0, 48'h001122334455, 48'h66778899AABB, 1'b1, 16'h3FFF, 16'h88F7));
        baStart = ba64;
        sendFrame(1'b1, 64, 18, stalls);
        checkOutput("dw64 tagged beat count", ba64 - baStart, 64'd8);
        idle(3);

        // Wide bus single-beat frame: frame_start and s_last together, runt.
        buildFrame(48'h0, 48'h0, 1'b0, 16'h0, 16'h0, 8);
        q64.push_back(mkExp(1'b1, 48'h0, 48'h0, 1'b0, 16'h0, 16'h0));
        sendFrame(1'b1, 8, 0, stalls);
        checkOutput("dw64 runt stalls", stalls, 64'd0);
        idle(5);

        checkOutput("dw8 scoreboard drained", q8.size(), 64'd0);
        checkOutput("dw64 scoreboard drained", q64.size(), 64'd0);
        checkOutput("dw8 frame_start count", fs8, 64'(expFrames8));
        checkOutput("dw8 beat_accept count", ba8, 64'(expBeats8));
        checkOutput("dw64 frame_start count", fs64, 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
